// File: rtl/hud_pkg.sv
// Shared constants, fetch FSM states and width helper for the lives HUD sequencer.
package hud_pkg;

    localparam int HUD_X     = 16;
    localparam int HUD_Y     = 464;
    localparam int STRIDE    = 10;
    localparam int H_ACTIVE  = 640;
    localparam int ICON_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        CAPTURE
    } fetch_state_t;

    // Width of a register able to hold 0..max_lives.
    function automatic int lives_w(input int max_lives);
        return (max_lives < 1) ? 1 : $clog2(max_lives + 1);
    endfunction

endpackage

// File: rtl/lives_counter.sv
// Saturating player lives register with event priority and a one-cycle-late
// game_over flag.
module lives_counter #(
    parameter int MAX_LIVES   = 5,
    parameter int START_LIVES = 3,
    parameter int LW          = hud_pkg::lives_w(MAX_LIVES)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          lose_life,
    input  logic          bonus_life,
    input  logic          new_game,
    output logic [LW-1:0] lives,
    output logic          game_over
);

    logic [LW-1:0] lives_n;

    // Simultaneous lose and bonus cancel out; new_game overrides everything.
    always_comb begin
        lives_n = lives;
        if (new_game) begin
            lives_n = LW'(START_LIVES);
        end else if (!(lose_life && bonus_life)) begin
            if (lose_life) begin
                if (lives != '0) begin
                    lives_n = lives - 1'b1;
                end
            end else if (bonus_life) begin
                if (lives < LW'(MAX_LIVES)) begin
                    lives_n = lives + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lives     <= LW'(START_LIVES);
            game_over <= 1'b0;
        end else begin
            lives     <= lives_n;
            game_over <= (lives == '0);
        end
    end

endmodule

// File: rtl/lives_hud_sequencer.sv
// Draws the lives count as a row of icons in the bottom HUD band: fetches the
// next icon row during horizontal blanking and serializes it during active video.
module lives_hud_sequencer #(
    parameter int HUD_X       = hud_pkg::HUD_X,
    parameter int HUD_Y       = hud_pkg::HUD_Y,
    parameter int STRIDE      = hud_pkg::STRIDE,
    parameter int MAX_LIVES   = 5,
    parameter int START_LIVES = 3,
    parameter int H_ACTIVE    = hud_pkg::H_ACTIVE,
    parameter int LW          = hud_pkg::lives_w(MAX_LIVES)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          pix_en,
    input  logic [9:0]    DrawX,
    input  logic [9:0]    DrawY,
    input  logic          lose_life,
    input  logic          bonus_life,
    input  logic          new_game,
    output logic [2:0]    font_addr,
    input  logic [7:0]    font_data,
    output logic          is_life,
    output logic [LW-1:0] lives,
    output logic          game_over
);
    import hud_pkg::*;

    // Wide enough to hold STRIDE-1 and to compare against ICON_SIZE.
    localparam int CW = $clog2(STRIDE + 1);

    fetch_state_t  state, state_n;
    logic          trigger;
    logic [10:0]   nl;
    logic          in_band;
    logic          band_q;
    logic          band_line;
    logic [7:0]    row_reg;
    logic [LW-1:0] lives_disp;

    logic          active, act_n;
    logic [CW-1:0] col, col_n;
    logic [LW-1:0] idx, idx_n;
    logic [2:0]    bit_sel;
    logic          pix_lit;

    lives_counter #(
        .MAX_LIVES   (MAX_LIVES),
        .START_LIVES (START_LIVES),
        .LW          (LW)
    ) u_lives_counter (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .lose_life  (lose_life),
        .bonus_life (bonus_life),
        .new_game   (new_game),
        .lives      (lives),
        .game_over  (game_over)
    );

    assign trigger   = pix_en && (DrawX == 10'(H_ACTIVE));
    assign nl        = {1'b0, DrawY} + 11'd1;
    assign in_band   = (nl >= 11'(HUD_Y)) && (nl < 11'(HUD_Y + ICON_SIZE));
    assign band_line = ({1'b0, DrawY} >= 11'(HUD_Y)) &&
                       ({1'b0, DrawY} < 11'(HUD_Y + ICON_SIZE));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (trigger) state_n = ADDR;
            ADDR:    state_n = CAPTURE;
            CAPTURE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // DrawY is stable for the whole blanking interval, so ADDR reads it directly.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            font_addr <= 3'd0;
            band_q    <= 1'b0;
            row_reg   <= 8'h00;
        end else begin
            state <= state_n;
            if (state == ADDR) begin
                band_q <= in_band;
                if (in_band) begin
                    font_addr <= 3'(nl - 11'(HUD_Y));
                end
            end
            if (state == CAPTURE) begin
                row_reg <= band_q ? font_data : 8'h00;
            end
        end
    end

    // Count is frozen at the top of the frame so the HUD never tears.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lives_disp <= LW'(START_LIVES);
        end else if (pix_en && (DrawX == 10'd0) && (DrawY == 10'd0)) begin
            lives_disp <= lives;
        end
    end

    // col/idx describe the pixel currently on DrawX once this strobe is applied.
    always_comb begin
        act_n = active;
        col_n = col;
        idx_n = idx;
        if (DrawX == 10'(HUD_X)) begin
            act_n = (lives_disp != '0);
            col_n = '0;
            idx_n = '0;
        end else if (DrawX >= 10'(H_ACTIVE)) begin
            act_n = 1'b0;
        end else if (active) begin
            if (col == CW'(STRIDE - 1)) begin
                col_n = '0;
                idx_n = idx + 1'b1;
                if (idx_n == lives_disp) begin
                    act_n = 1'b0;
                end
            end else begin
                col_n = col + 1'b1;
            end
        end
    end

    assign bit_sel = 3'd7 - col_n[2:0];
    assign pix_lit = act_n && band_line && (col_n < CW'(ICON_SIZE)) && row_reg[bit_sel];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            active  <= 1'b0;
            col     <= '0;
            idx     <= '0;
            is_life <= 1'b0;
        end else if (pix_en) begin
            active  <= act_n;
            col     <= col_n;
            idx     <= idx_n;
            is_life <= pix_lit;
        end
    end

endmodule
